// File: rtl/wide_alu_seq.sv
// rtl/wide_alu_seq.sv - 64-bit operation sequencer over a shared 32-bit ALU, one half per cycle.
// Low word in LO, high word with chained carry in HI, merged NZCV written on HI->DONE.
module wide_alu_seq #(
  parameter logic [3:0] STATUS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        set_flags,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [3:0]  status_reg,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        alu_c_in,
  output logic [3:0]  alu_exe_cmd,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_status
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_MVN = 3'b110;
  localparam logic [2:0] OP_ADC = 3'b111;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [2:0]  op_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic        sf_q;
  logic [31:0] res_lo;
  logic        carry_lo;
  logic        z_lo;
  logic        is_arith;

  function automatic logic [3:0] lo_cmd(input logic [2:0] o);
    case (o)
      OP_ADD:  lo_cmd = CMD_ADD;
      OP_SUB:  lo_cmd = CMD_SUB;
      OP_AND:  lo_cmd = CMD_AND;
      OP_ORR:  lo_cmd = CMD_ORR;
      OP_EOR:  lo_cmd = CMD_EOR;
      OP_MOV:  lo_cmd = CMD_MOV;
      OP_MVN:  lo_cmd = CMD_MVN;
      default: lo_cmd = CMD_ADC;
    endcase
  endfunction

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADC);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 3'b000;
      a_q        <= 64'd0;
      b_q        <= 64'd0;
      sf_q       <= 1'b0;
      res_lo     <= 32'd0;
      carry_lo   <= 1'b0;
      z_lo       <= 1'b0;
      result     <= 64'd0;
      status_reg <= STATUS_RST;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            sf_q <= set_flags;
          end
        end
        LO: begin
          res_lo   <= alu_result;
          carry_lo <= alu_status[1];
          z_lo     <= alu_status[2];
        end
        HI: begin
          result <= {alu_result, res_lo};
          // Logical ops leave C and V as they were; only arithmetic ops own them.
          if (sf_q) begin
            status_reg <= {alu_result[31],
                           z_lo && (alu_result == 32'd0),
                           is_arith ? alu_status[1] : status_reg[1],
                           is_arith ? alu_status[0] : status_reg[0]};
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    alu_in1     = 32'd0;
    alu_in2     = 32'd0;
    alu_c_in    = 1'b0;
    alu_exe_cmd = CMD_NOP;
    case (state)
      IDLE: if (start) state_next = LO;
      LO: begin
        state_next  = HI;
        alu_in1     = a_q[31:0];
        alu_in2     = b_q[31:0];
        alu_exe_cmd = lo_cmd(op_q);
        alu_c_in    = (op_q == OP_ADC) ? status_reg[1] : 1'b0;
      end
      HI: begin
        state_next = DONE;
        alu_in1    = a_q[63:32];
        alu_in2    = b_q[63:32];
        alu_c_in   = carry_lo;
        case (op_q)
          OP_ADD, OP_ADC: alu_exe_cmd = CMD_ADC;
          OP_SUB:         alu_exe_cmd = CMD_SBC;
          default:        alu_exe_cmd = lo_cmd(op_q);
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wide_alu_seq.sv
// tb/tb_wide_alu_seq.sv - self-checking bench for wide_alu_seq with a behavioural 32-bit ALU.
// Table vectors, reset/held-start sequences and random ops feed a result scoreboard.
module tb_wide_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        set_flags;
  logic        busy, done;
  logic [63:0] result;
  logic [3:0]  status_reg;
  logic [31:0] alu_in1, alu_in2;
  logic        alu_c_in;
  logic [3:0]  alu_exe_cmd;
  logic [31:0] alu_result;
  logic [3:0]  alu_status;

  int checks = 0;
  int failures = 0;
  logic [67:0] sb_q[$];
  logic [3:0]  exp_status;

  always #5 clk = ~clk;

  wide_alu_seq #(.STATUS_RST(4'b0000)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .set_flags(set_flags), .busy(busy), .done(done), .result(result),
    .status_reg(status_reg), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_c_in(alu_c_in), .alu_exe_cmd(alu_exe_cmd),
    .alu_result(alu_result), .alu_status(alu_status)
  );

  // Reference 32-bit ALU: ARM-style flags, C=1 means no borrow on subtract.
  logic [32:0] alu_s;
  logic [31:0] alu_bb;
  logic        alu_ar;
  always_comb begin
    alu_s  = 33'd0;
    alu_bb = alu_in2;
    alu_ar = 1'b0;
    case (alu_exe_cmd)
      4'b0001: alu_s = {1'b0, alu_in2};
      4'b1001: alu_s = {1'b0, ~alu_in2};
      4'b0010: begin alu_ar = 1'b1; alu_s = {1'b0, alu_in1} + {1'b0, alu_in2}; end
      4'b0011: begin alu_ar = 1'b1; alu_s = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'd0, alu_c_in}; end
      4'b0100: begin alu_ar = 1'b1; alu_bb = ~alu_in2; alu_s = {1'b0, alu_in1} + {1'b0, alu_bb} + 33'd1; end
      4'b0101: begin alu_ar = 1'b1; alu_bb = ~alu_in2; alu_s = {1'b0, alu_in1} + {1'b0, alu_bb} + {32'd0, alu_c_in}; end
      4'b0110: alu_s = {1'b0, alu_in1 & alu_in2};
      4'b0111: alu_s = {1'b0, alu_in1 | alu_in2};
      4'b1000: alu_s = {1'b0, alu_in1 ^ alu_in2};
      default: alu_s = 33'd0;
    endcase
    alu_result = alu_s[31:0];
    alu_status = {alu_s[31], alu_s[31:0] == 32'd0,
                  alu_ar ? alu_s[32] : alu_c_in,
                  alu_ar && (alu_in1[31] == alu_bb[31]) && (alu_s[31] != alu_in1[31])};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // 64-bit reference: returns {result, nzcv} given the status before the op.
  function automatic logic [67:0] model64(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                                          input logic sf, input logic [3:0] st);
    logic [64:0] s;
    logic [63:0] yy;
    logic        ar;
    logic [3:0]  ns;
    yy = y;
    ar = 1'b1;
    case (o)
      3'b000: s = {1'b0, x} + {1'b0, y};
      3'b001: begin yy = ~y; s = {1'b0, x} + {1'b0, yy} + 65'd1; end
      3'b111: s = {1'b0, x} + {1'b0, y} + {64'd0, st[1]};
      3'b010: begin ar = 1'b0; s = {1'b0, x & y}; end
      3'b011: begin ar = 1'b0; s = {1'b0, x | y}; end
      3'b100: begin ar = 1'b0; s = {1'b0, x ^ y}; end
      3'b101: begin ar = 1'b0; s = {1'b0, y}; end
      default: begin ar = 1'b0; s = {1'b0, ~y}; end
    endcase
    ns = {s[63], s[63:0] == 64'd0,
          ar ? s[64] : st[1],
          ar ? ((x[63] == yy[63]) && (s[63] != x[63])) : st[0]};
    model64 = {s[63:0], sf ? ns : st};
  endfunction

  function automatic logic [7:0] cmds_for(input logic [2:0] o);
    case (o)
      3'b000: cmds_for = 8'h23;
      3'b001: cmds_for = 8'h45;
      3'b010: cmds_for = 8'h66;
      3'b011: cmds_for = 8'h77;
      3'b100: cmds_for = 8'h88;
      3'b101: cmds_for = 8'h11;
      3'b110: cmds_for = 8'h99;
      default: cmds_for = 8'h33;
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [67:0] e;
        e = sb_q.pop_front();
        chk("sb_result", result, e[67:4]);
        chk("sb_status", {60'd0, status_reg}, {60'd0, e[3:0]});
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y, input logic sf,
                        input logic [63:0] er, input logic [3:0] es, input logic [7:0] cmds);
    @(negedge clk);
    op = o; a = x; b = y; set_flags = sf; start = 1'b1;
    sb_q.push_back({er, es});
    @(negedge clk);
    start = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom_range(0, 7));
    chk("busy_lo", {63'd0, busy}, 64'd1);
    chk("cmd_lo", {60'd0, alu_exe_cmd}, {60'd0, cmds[7:4]});
    @(negedge clk);
    chk("cmd_hi", {60'd0, alu_exe_cmd}, {60'd0, cmds[3:0]});
    chk("done_early", {63'd0, done}, 64'd0);
    @(negedge clk);
    chk("done_latency", {63'd0, done}, 64'd1);
    chk("cmd_done_nop", {60'd0, alu_exe_cmd}, 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_after", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        sf;
    logic [63:0] res;
    logic [3:0]  st;
    logic [7:0]  cmds;
  } vec_t;

  vec_t tv[10];
  logic [63:0] va[3];
  logic [63:0] vb[3];

  initial begin
    tv[0] = '{3'b000, 64'h00000000_FFFFFFFF, 64'd1, 1'b1, 64'h00000001_00000000, 4'b0000, 8'h23};
    tv[1] = '{3'b000, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 1'b1, 64'h80000000_00000000, 4'b1001, 8'h23};
    tv[2] = '{3'b001, 64'd0, 64'd1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 4'b1000, 8'h45};
    tv[3] = '{3'b001, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b1, 64'd0, 4'b0110, 8'h45};
    tv[4] = '{3'b100, 64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001, 1'b1, 64'd0, 4'b0110, 8'h88};
    tv[5] = '{3'b111, 64'd0, 64'd0, 1'b1, 64'd1, 4'b0000, 8'h33};
    tv[6] = '{3'b101, 64'd5, 64'h01234567_89ABCDEF, 1'b0, 64'h01234567_89ABCDEF, 4'b0000, 8'h11};
    tv[7] = '{3'b010, 64'hF0F0F0F0_F0F0F0F0, 64'hFF00FF00_FF00FF00, 1'b1, 64'hF000F000_F000F000, 4'b1000, 8'h66};
    tv[8] = '{3'b110, 64'd0, 64'hFFFFFFFF_00000000, 1'b1, 64'h00000000_FFFFFFFF, 4'b0000, 8'h99};
    tv[9] = '{3'b011, 64'h80000000_00000000, 64'd1, 1'b1, 64'h80000000_00000001, 4'b1000, 8'h77};

    rst = 1'b1; start = 1'b0; op = 3'b000; a = 64'd0; b = 64'd0; set_flags = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_status", {60'd0, status_reg}, 64'd0);
    chk("rst_cmd", {60'd0, alu_exe_cmd}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].sf, tv[i].res, tv[i].st, tv[i].cmds);

    // Reset in HI aborts the op: no done, no status update.
    @(negedge clk);
    op = 3'b000; a = 64'd10; b = 64'd20; set_flags = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", result, 64'd0);
    chk("abort_status", {60'd0, status_reg}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", {63'd0, done}, 64'd0);
    end
    exp_status = 4'b0000;
    run_op(3'b000, 64'd3, 64'd4, 1'b1, 64'd7, 4'b0000, 8'h23);

    // start held high: accepted only from IDLE, operands ignored while busy.
    va[0] = 64'h00000001_00000002; vb[0] = 64'h00000003_00000004;
    va[1] = 64'hFFFFFFFF_FFFFFFFF; vb[1] = 64'h00000000_00000002;
    va[2] = 64'h12345678_00000000; vb[2] = 64'h00000000_87654321;
    op = 3'b000; set_flags = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k > 0) chk("held_idle", {63'd0, busy}, 64'd0);
      a = va[k]; b = vb[k]; start = 1'b1;
      sb_q.push_back({va[k] + vb[k], exp_status});
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        chk("held_no_done", {63'd0, done}, 64'd0);
      end
      @(negedge clk);
      chk("held_done", {63'd0, done}, 64'd1);
    end
    @(negedge clk);
    start = 1'b0;

    // Random ops against the 64-bit reference, with status tracked across ops.
    for (int r = 0; r < 16; r++) begin
      logic [2:0]  ro;
      logic [63:0] ra, rb;
      logic        rs;
      logic [67:0] m;
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = (r % 4 == 0) ? ~ra : {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      m  = model64(ro, ra, rb, rs, exp_status);
      run_op(ro, ra, rb, rs, m[67:4], m[3:0], cmds_for(ro));
      exp_status = m[3:0];
    end

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
